// File: rtl/soc_noc_arb_pkg.sv
// soc_noc_arb_pkg
//   Shared types and helpers for the NoC link arbiter.
//   - arb_state_t : arbiter FSM states (idle / locked on a packet owner)
//   - rr_select   : round-robin pick of the first requester at or after a
//                   pointer, with wrap-around, returned as a one-hot vector
package soc_noc_arb_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  // Widest requester vector rr_select can handle; callers zero-extend.
  localparam int unsigned ARB_MAX_REQ = 16;
  localparam int unsigned ARB_IDX_W   = $clog2(ARB_MAX_REQ);

  // req : request vector (bits at and above n are ignored)
  // ptr : search start, must be < n
  // n   : number of live requesters
  function automatic logic [ARB_MAX_REQ-1:0] rr_select(
    input logic [ARB_MAX_REQ-1:0] req,
    input int unsigned            ptr,
    input int unsigned            n
  );
    logic [ARB_MAX_REQ-1:0] gnt;
    logic                   found;
    int unsigned            idx;
    gnt   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < ARB_MAX_REQ; i++) begin
      // ptr < n, so a single subtraction implements the wrap.
      idx = ptr + i;
      if (idx >= n) idx = idx - n;
      if (i < n && !found && idx < ARB_MAX_REQ && req[idx[ARB_IDX_W-1:0]]) begin
        gnt[idx[ARB_IDX_W-1:0]] = 1'b1;
        found                   = 1'b1;
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/soc_noc_arb_skid.sv
// soc_noc_arb_skid
//   Two-entry skid buffer placed on the arbiter output when
//   SOC_NOC_ARB_OUTREG_EN is defined. Outputs come straight from registers
//   and in_ready depends only on the occupancy register, so there is no
//   combinational path from out_ready back to in_ready. Two entries let a
//   push and a pop happen every cycle without bubbles.
//
// Ports
//   clk, rst            clock, asynchronous active-low reset (empties buffer)
//   in_data/valid/ready upstream handshake
//   out_data/valid/ready downstream handshake (out_data is 0 while empty)
module soc_noc_arb_skid #(
  parameter int unsigned W = 33
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;
  logic         push;
  logic         pop;

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; out_data is masked while the buffer is empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

endmodule

// File: rtl/soc_noc_link_arbiter.sv
// soc_noc_link_arbiter
//   Packet-level round-robin arbiter sharing one NoC link between
//   REQUESTERS flit sources. A grant is held from the first flit to the last
//   flit of a packet; packets longer than MAX_PKT_LEN are cut with a forced
//   last flit and flagged on err_overlen / err_src.
//
//   Build option: define SOC_NOC_ARB_OUTREG_EN to register the output
//   through a 2-entry skid buffer (+1 latency, full throughput, no
//   out_ready -> in_ready combinational path). Undefined: pass-through.
//
// Ports
//   clk, rst      clock, asynchronous active-low reset
//   in_flit/last/valid, in_ready   per-source flit interfaces
//   out_flit/last/valid, out_ready link towards the NoC
//   grant         one-hot owner, 0 while idle
//   err_overlen   one-cycle pulse after a forced packet termination
//   err_src       source index of the last forced termination (held)
module soc_noc_link_arbiter
  import soc_noc_arb_pkg::*;
#(
  parameter int unsigned FLIT_WIDTH  = 32,
  parameter int unsigned REQUESTERS  = 3,
  parameter int unsigned MAX_PKT_LEN = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [REQUESTERS-1:0][FLIT_WIDTH-1:0] in_flit,
  input  logic [REQUESTERS-1:0]                 in_last,
  input  logic [REQUESTERS-1:0]                 in_valid,
  output logic [REQUESTERS-1:0]                 in_ready,
  output logic [FLIT_WIDTH-1:0]                 out_flit,
  output logic                                  out_last,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [REQUESTERS-1:0]                 grant,
  output logic                                  err_overlen,
  output logic [$clog2(REQUESTERS)-1:0]         err_src
);

  localparam int unsigned IDX_W = $clog2(REQUESTERS);
  localparam int unsigned CNT_W = $clog2(MAX_PKT_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(REQUESTERS - 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_PKT_LEN - 1);

  arb_state_t              state;
  arb_state_t              state_nxt;
  logic [REQUESTERS-1:0]   grant_nxt;
  logic [IDX_W-1:0]        rr_ptr;
  logic [IDX_W-1:0]        rr_ptr_nxt;
  logic [IDX_W-1:0]        owner;
  logic [CNT_W-1:0]        cnt;
  logic [ARB_MAX_REQ-1:0]  rr_pick_full;
  logic                    unused_rr_pick;

  logic                    locked;
  logic                    own_valid;
  logic                    own_last;
  logic [FLIT_WIDTH-1:0]   own_flit;
  logic                    forced_last;
  logic                    link_ready;
  logic                    fire;

  assign rr_pick_full   = rr_select(ARB_MAX_REQ'(in_valid), 32'(rr_ptr), REQUESTERS);
  assign unused_rr_pick = ^rr_pick_full;

  // Owner index from the one-hot grant register.
  always_comb begin
    owner = '0;
    for (int unsigned i = 0; i < REQUESTERS; i++) begin
      if (grant[i]) owner = IDX_W'(i);
    end
  end

  assign locked      = (state == ARB_LOCKED);
  assign forced_last = locked && (cnt == CNT_LIMIT) && !in_last[owner];
  assign own_valid   = locked & in_valid[owner];
  assign own_last    = locked & (in_last[owner] | forced_last);
  assign own_flit    = locked ? in_flit[owner] : '0;
  assign fire        = own_valid & link_ready;
  assign rr_ptr_nxt  = (owner == LAST_IDX) ? '0 : owner + 1'b1;

  // grant is 0 while idle, which also keeps every in_ready low.
  assign in_ready    = grant & {REQUESTERS{link_ready}};

`ifdef SOC_NOC_ARB_OUTREG_EN
  logic [FLIT_WIDTH:0] skid_out;

  // Lock release follows the flit entering the buffer, not leaving it.
  soc_noc_arb_skid #(
    .W(FLIT_WIDTH + 1)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .in_data  ({own_last, own_flit}),
    .in_valid (own_valid),
    .in_ready (link_ready),
    .out_data (skid_out),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  assign {out_last, out_flit} = skid_out;
`else
  assign link_ready = out_ready;
  assign out_flit   = own_flit;
  assign out_last   = own_last;
  assign out_valid  = own_valid;
`endif

  // FSM: next state and grant
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    case (state)
      ARB_IDLE: begin
        if (|in_valid) begin
          grant_nxt = rr_pick_full[REQUESTERS-1:0];
          state_nxt = ARB_LOCKED;
        end
      end
      ARB_LOCKED: begin
        if (fire && own_last) begin
          grant_nxt = '0;
          state_nxt = ARB_IDLE;
        end
      end
      default: begin
        grant_nxt = '0;
        state_nxt = ARB_IDLE;
      end
    endcase
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ARB_IDLE;
      grant <= '0;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
    end
  end

  // Packet bookkeeping: flit counter, fairness pointer, error reporting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr      <= '0;
      cnt         <= '0;
      err_overlen <= 1'b0;
      err_src     <= '0;
    end else begin
      err_overlen <= fire & forced_last;
      if (fire) begin
        if (own_last) begin
          cnt    <= '0;
          rr_ptr <= rr_ptr_nxt;
        end else begin
          cnt    <= cnt + 1'b1;
        end
        if (forced_last) err_src <= owner;
      end
    end
  end

endmodule

// File: tb/tb_soc_noc_link_arbiter.sv
module tb_soc_noc_link_arbiter;

  localparam int FW  = 32;
  localparam int NR  = 3;
  localparam int MPL = 16;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [NR-1:0][FW-1:0]  in_flit = '0;
  logic [NR-1:0]          in_last = '0;
  logic [NR-1:0]          in_valid = '0;
  logic [NR-1:0]          in_ready;
  logic [FW-1:0]          out_flit;
  logic                   out_last;
  logic                   out_valid;
  logic                   out_ready = 1'b0;
  logic [NR-1:0]          grant;
  logic                   err_overlen;
  logic [1:0]             err_src;

  always #5 clk = ~clk;

  soc_noc_link_arbiter #(
    .FLIT_WIDTH (FW),
    .REQUESTERS (NR),
    .MAX_PKT_LEN(MPL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_flit    (in_flit),
    .in_last    (in_last),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_flit   (out_flit),
    .out_last   (out_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .grant      (grant),
    .err_overlen(err_overlen),
    .err_src    (err_src)
  );

  typedef struct packed { logic last; logic [FW-1:0] flit; } ent_t;
  typedef struct { int src; logic [FW-1:0] flit; logic last; } exp_t;

  ent_t  src_q [NR][$];   // flits each source still has to send
  exp_t  exp_q [$];       // expected link transfers, in order
  int    err_q [$];       // expected err_src per forced termination
  int    served_q [$];    // source of every completed packet

  int total = 0;
  int bad   = 0;
  int seq   = 0;
  int tick  = 0;
  int err_seen = 0;
  int xfer_cnt = 0;
  int last_xfer_tick = 0;

  // Reference model: abstract owner / pointer / length count.
  int m_owner = -1;
  int m_rr    = 0;
  int m_cnt   = 0;

  // Stimulus controls.
  logic          rst_cmd    = 1'b0;
  logic [NR-1:0] vld_mask   = '1;
  int            rand_vld   = 0;
  int            ready_mode = 0;   // 0: always 1, 1: toggle, 2: random

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, req, $time);
    end
  endtask

  task automatic add_pkt(input int s, input int len, input bit with_last);
    ent_t e;
    for (int k = 0; k < len; k++) begin
      e.flit = {s[3:0], seq[11:0], 16'($urandom)};
      e.last = with_last && (k == len - 1);
      seq++;
      src_q[s].push_back(e);
    end
  endtask

  function automatic int pending();
    int p;
    p = exp_q.size();
    for (int i = 0; i < NR; i++) p += src_q[i].size();
    return p;
  endfunction

  task automatic model_step();
    logic [NR-1:0] eg;
    int   g;
    bit   forced;
    bit   last;
    if (rst === 1'b0) begin
      m_owner = -1;
      m_rr    = 0;
      m_cnt   = 0;
      chk("rst_grant",     grant,       0);
      chk("rst_in_ready",  in_ready,    0);
      chk("rst_out_valid", out_valid,   0);
      chk("rst_out_flit",  out_flit,    0);
      chk("rst_out_last",  out_last,    0);
      chk("rst_err",       err_overlen, 0);
      chk("rst_err_src",   err_src,     0);
      return;
    end
    eg = (m_owner < 0) ? '0 : (NR'(1) << m_owner);
    chk("grant",     grant,     eg);
    chk("in_ready",  in_ready,  (m_owner >= 0 && out_ready) ? eg : '0);
    chk("out_valid", out_valid, (m_owner >= 0) ? in_valid[m_owner] : 1'b0);
    if (m_owner < 0) begin
      for (int k = 0; k < NR; k++) begin
        if (in_valid[(m_rr + k) % NR]) begin
          m_owner = (m_rr + k) % NR;
          break;
        end
      end
    end else if (in_valid[m_owner] && out_ready) begin
      g      = m_owner;
      forced = (m_cnt == MPL - 1) && !in_last[g];
      last   = in_last[g] || forced;
      exp_q.push_back('{g, in_flit[g], last});
      void'(src_q[g].pop_front());
      if (forced) err_q.push_back(g);
      m_cnt++;
      if (last) begin
        m_owner = -1;
        m_rr    = (g + 1) % NR;
        m_cnt   = 0;
      end
    end
  endtask

  // One clock: drive just after the edge, then let the model predict.
  task automatic cycle();
    @(posedge clk);
    #1;
    tick++;
    rst = rst_cmd;
    for (int i = 0; i < NR; i++) begin
      if (src_q[i].size() > 0) begin
        in_flit[i]  = src_q[i][0].flit;
        in_last[i]  = src_q[i][0].last;
        in_valid[i] = vld_mask[i] && (rand_vld == 0 || $urandom_range(0, 3) != 0);
      end else begin
        in_flit[i]  = '0;
        in_last[i]  = 1'b0;
        in_valid[i] = 1'b0;
      end
    end
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = (tick % 2 == 0);
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
    #1;
    model_step();
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (n < budget && pending() != 0) begin
      cycle();
      n++;
    end
    chk("drain_left", pending(), 0);
  endtask

  // Monitor: compares every link transfer and error pulse with the queues.
  always @(negedge clk) begin
    exp_t e;
    int   s;
    if (rst === 1'b1) begin
      if (out_valid && out_ready) begin
        xfer_cnt++;
        last_xfer_tick = tick;
        if (exp_q.size() == 0) begin
          chk("spurious_xfer", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          chk("out_flit",   out_flit, e.flit);
          chk("out_last",   out_last, e.last);
          chk("xfer_owner", grant,    NR'(1) << e.src);
          if (e.last) served_q.push_back(e.src);
        end
      end
      if (err_overlen) begin
        err_seen++;
        if (err_q.size() == 0) begin
          chk("spurious_err", err_q.size(), 1);
        end else begin
          s = err_q.pop_front();
          chk("err_src", err_src, s);
        end
      end
    end
  end

  initial begin
    int rel_tick;
    int x0;
    int e0;
    int s;

    // Reset held with all sources requesting, then round-robin under load.
    for (int i = 0; i < NR; i++) add_pkt(i, 2, 1);
    for (int i = 0; i < NR; i++) add_pkt(i, 2, 1);
    rst_cmd = 1'b0;
    repeat (3) cycle();
    rst_cmd  = 1'b1;
    rel_tick = tick + 1;
    drain(200);
    chk("rr_count", served_q.size(), 6);
    for (int k = 0; k < 6 && k < served_q.size(); k++)
      chk($sformatf("rr_order_%0d", k), served_q[k], k % 3);
    chk("rr_last_xfer_cycle", last_xfer_tick - rel_tick, 17);

    // Backpressure on a 4-flit packet from source 1.
    served_q.delete();
    x0 = xfer_cnt;
    add_pkt(1, 4, 1);
    ready_mode = 1;
    drain(100);
    ready_mode = 0;
    chk("bp_xfers", xfer_cnt - x0, 4);
    chk("bp_served", served_q.size() == 1 ? served_q[0] : -1, 1);

    // Overlength packet from source 2 with source 0 waiting.
    served_q.delete();
    e0 = err_seen;
    add_pkt(2, 20, 0);
    add_pkt(2, 1, 1);
    add_pkt(0, 2, 1);
    drain(200);
    chk("ovl_err_pulses", err_seen - e0, 1);
    chk("ovl_err_src_held", err_src, 2);
    chk("ovl_served_n", served_q.size(), 3);
    if (served_q.size() == 3) begin
      chk("ovl_served_0", served_q[0], 2);
      chk("ovl_served_1", served_q[1], 0);
      chk("ovl_served_2", served_q[2], 2);
    end

    // Owner stalls mid-packet while source 1 requests.
    served_q.delete();
    add_pkt(0, 4, 1);
    add_pkt(1, 2, 1);
    repeat (3) cycle();
    vld_mask = 3'b110;
    repeat (5) cycle();
    vld_mask = 3'b111;
    drain(100);
    chk("stall_served_n", served_q.size(), 2);
    if (served_q.size() == 2) begin
      chk("stall_served_0", served_q[0], 0);
      chk("stall_served_1", served_q[1], 1);
    end

    // Asynchronous reset during flit 2 of 4.
    served_q.delete();
    add_pkt(1, 4, 1);
    cycle();
    cycle();
    add_pkt(0, 1, 1);
    add_pkt(2, 1, 1);
    rst_cmd = 1'b0;
    cycle();
    cycle();
    rst_cmd = 1'b1;
    cycle();
    cycle();
    chk("restart_grant", grant, 3'b001);
    drain(100);
    chk("restart_served_n", served_q.size(), 3);
    if (served_q.size() == 3) begin
      chk("restart_served_0", served_q[0], 0);
      chk("restart_served_1", served_q[1], 1);
      chk("restart_served_2", served_q[2], 2);
    end

    // Randomized traffic, valids and backpressure.
    rand_vld   = 1;
    ready_mode = 2;
    repeat (3000) begin
      if ($urandom_range(0, 4) == 0) begin
        s = $urandom_range(0, NR - 1);
        if (src_q[s].size() < 40) add_pkt(s, $urandom_range(1, 20), 1);
      end
      cycle();
    end
    rand_vld   = 0;
    ready_mode = 0;
    drain(3000);
    repeat (2) cycle();
    chk("exp_left", exp_q.size(), 0);
    chk("err_left", err_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
